// File: rtl/ps2_key_driver.sv
// ----------------------------------------------------------------------------
// ps2_key_driver
//   PS/2 keyboard receiver. Frames arriving on PS2_CLK/PS2_DAT are filtered,
//   deframed and checked; valid scan-code bytes are buffered in a FIFO that
//   the CPU reads and pops through the key io port. A successful push raises
//   io_irq, which is held until acknowledged on io_reset_irq.
//
// Ports
//   CLOCK_50      in   system clock, the only clock
//   reset         in   synchronous active-high reset
//   PS2_CLK       in   raw keyboard clock (asynchronous)
//   PS2_DAT       in   raw keyboard data (asynchronous)
//   io_raddr      in   read address, bit 0 selects DATA(0)/STATUS(1)
//   io_rdata      out  registered read data
//   io_waddr      in   write address, bit 0 selects POP(0)/CLEAR(1)
//   io_wdata      in   write data, bits [2:1] are write-1-to-clear flags
//   io_wenable    in   one-cycle write strobe
//   io_irq        out  key interrupt request
//   io_reset_irq  in   interrupt acknowledge (level, rising edge acts)
// ----------------------------------------------------------------------------
module ps2_key_driver #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  input  logic [15:0] io_raddr,
  output logic [15:0] io_rdata,
  input  logic [15:0] io_waddr,
  input  logic [15:0] io_wdata,
  input  logic        io_wenable,
  output logic        io_irq,
  input  logic        io_reset_irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]    FULL_CNT = 6'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_STOP} state_t;

  // Input conditioning
  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt;
  logic [FW-1:0] r_filt_cnt;
  logic          w_filt_flip, w_fall;

  // Receiver
  state_t        r_state, w_state_next;
  logic [3:0]    r_bitcnt;
  logic [8:0]    r_shift;     // {parity, data[7:0]} once a frame is complete
  logic          r_start;
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout, w_frame_done, w_frame_ok;

  // FIFO, flags, irq
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [5:0]    r_count;
  logic          r_overflow, r_frame_err, r_irq, r_ack_d, r_dat_unused;
  logic [15:0]   r_rdata;
  logic          w_empty, w_full, w_pop, w_push, w_ovf_set, w_clr, w_ack_rise;
  logic [15:0]   w_status;
  logic          w_unused;

  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1 <= PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2_DAT;
      r_dat_s2 <= r_dat_s1;
      // Count consecutive samples that disagree with the filtered level;
      // any agreeing sample restarts the count.
      if (w_filt_flip) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
      end else if (r_clk_s2 != r_filt) begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_filt_flip = (r_clk_s2 != r_filt) && (r_filt_cnt == FILT_MAX);
  assign w_fall      = w_filt_flip && r_filt;

  // FSM: state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM: next state
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_fall) w_state_next = S_RECV;
      S_RECV: begin
        if (w_fall) begin
          if (r_bitcnt == 4'd9) w_state_next = S_STOP;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
        end
      end
      S_STOP: if (w_fall || w_timeout) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs. Odd parity means data+parity carries an odd count of ones.
  always_comb begin
    w_timeout    = (r_state != S_IDLE) && (r_to_cnt == TO_MAX);
    w_frame_done = (r_state == S_STOP) && w_fall;
    w_frame_ok   = w_frame_done && !r_start && r_dat_s2 && (^r_shift);
  end

  // Receiver datapath
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_start  <= 1'b1;
      r_to_cnt <= '0;
    end else begin
      if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
      else                             r_to_cnt <= r_to_cnt + 1'b1;
      if (w_fall) begin
        if (r_state == S_IDLE) begin
          r_start  <= r_dat_s2;
          r_bitcnt <= 4'd1;
        end else if (r_state == S_RECV) begin
          r_shift  <= {r_dat_s2, r_shift[8:1]};   // LSB first
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end
    end
  end

  // FIFO control. A pop in the same cycle frees the slot, so a push into a
  // full FIFO is still accepted when paired with a pop.
  assign w_empty    = (r_count == 6'd0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = io_wenable && !io_waddr[0] && !w_empty;
  assign w_push     = w_frame_ok && (!w_full || w_pop);
  assign w_ovf_set  = w_frame_ok && w_full && !w_pop;
  assign w_clr      = io_wenable && io_waddr[0];
  assign w_ack_rise = io_reset_irq && !r_ack_d;
  assign w_status   = {2'b00, r_count, 5'b00000, r_frame_err, r_overflow, !w_empty};

  // NOTE: the storage array carries no reset; entries are only ever read
  // behind r_count, so stale contents are never visible.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wptr] <= r_shift[7:0];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_irq        <= 1'b0;
      r_ack_d      <= 1'b0;
      r_rdata      <= '0;
      r_dat_unused <= 1'b0;
    end else begin
      r_ack_d <= io_reset_irq;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 6'd1;
        2'b01:   r_count <= r_count - 6'd1;
        default: r_count <= r_count;
      endcase
      // Set has priority over a same-cycle clear.
      r_overflow  <= w_ovf_set || (r_overflow && !(w_clr && io_wdata[1]));
      r_frame_err <= (w_frame_done && !w_frame_ok) ||
                     (r_frame_err && !(w_clr && io_wdata[2]));
      // A push keeps irq asserted even against a coincident acknowledge.
      if (w_push)          r_irq <= 1'b1;
      else if (w_ack_rise) r_irq <= 1'b0;
      if (io_raddr[0])  r_rdata <= w_status;
      else if (w_empty) r_rdata <= 16'h0000;
      else              r_rdata <= {8'h00, r_mem[r_rptr]};
      r_dat_unused <= 1'b0;
    end
  end

  assign io_rdata = r_rdata;
  assign io_irq   = r_irq;

  // Address/data bits that the register map does not decode.
  assign w_unused = &{1'b0, io_raddr[15:1], io_waddr[15:1], io_wdata[15:3],
                      io_wdata[0], r_dat_unused};

endmodule

// File: tb/tb_ps2_key_driver.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_driver
//   Self-checking bench for ps2_key_driver. PS/2 frames are bit-banged at a
//   scaled bit rate (HALF CLOCK_50 cycles per PS2_CLK phase) with a shortened
//   timeout so the whole run stays short. A byte queue plus overflow and
//   frame-error flags model the expected FIFO contents and STATUS value.
// ----------------------------------------------------------------------------
module tb_ps2_key_driver;

  localparam int HALF    = 25;
  localparam int TIMEOUT = 400;
  localparam int DEPTH   = 16;

  logic        clk, reset, ps2_clk, ps2_dat;
  logic [15:0] io_raddr, io_rdata, io_waddr, io_wdata;
  logic        io_wenable, io_irq, io_reset_irq;

  logic [7:0] q_exp[$];
  bit         ovf_exp, ferr_exp;
  int         checks, errors;

  ps2_key_driver #(
    .FIFO_DEPTH    (DEPTH),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .PS2_CLK     (ps2_clk),
    .PS2_DAT     (ps2_dat),
    .io_raddr    (io_raddr),
    .io_rdata    (io_rdata),
    .io_waddr    (io_waddr),
    .io_wdata    (io_wdata),
    .io_wenable  (io_wenable),
    .io_irq      (io_irq),
    .io_reset_irq(io_reset_irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_status();
    logic [5:0] cnt;
    cnt = 6'(q_exp.size());
    return {2'b00, cnt, 5'b00000, ferr_exp, ovf_exp, (q_exp.size() != 0)};
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (q_exp.size() < DEPTH) q_exp.push_back(b);
    else                      ovf_exp = 1'b1;
  endtask

  task automatic read_reg(input logic [15:0] addr, output logic [15:0] val);
    @(negedge clk);
    io_raddr = addr;
    @(negedge clk);
    val = io_rdata;
  endtask

  task automatic write_reg(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    io_waddr   = addr;
    io_wdata   = data;
    io_wenable = 1'b1;
    @(negedge clk);
    io_wenable = 1'b0;
  endtask

  task automatic ack_irq();
    @(negedge clk);
    io_reset_irq = 1'b1;
    @(negedge clk);
    io_reset_irq = 1'b0;
  endtask

  // Sends the first nbits of a frame. With pop/ack set, the strobe lands on
  // the cycle the stop bit's filtered falling edge pushes the byte: PS2_CLK
  // low at negedge N0, two synchronizer stages plus eight filter samples put
  // that push on the posedge right after negedge N9.
  task automatic send_frame(input logic [7:0] data, input bit bad_par,
                            input int nbits, input bit pop_at_stop,
                            input bit ack_at_stop);
    logic [10:0] f;
    logic        par;
    par = (~^data) ^ bad_par;
    f   = {1'b1, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_dat = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && (pop_at_stop || ack_at_stop)) begin
        repeat (9) @(negedge clk);
        if (pop_at_stop) begin
          io_waddr   = 16'h0000;
          io_wenable = 1'b1;
        end
        if (ack_at_stop) io_reset_irq = 1'b1;
        @(negedge clk);
        io_wenable = 1'b0;
        repeat (HALF - 10) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (io_rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata: got %h expected %h", io_rdata, 16'h0000);
    end
    checks++;
    if (io_irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b expected 0", io_irq);
    end
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL reset_status: got %h expected %h", v, exp_status());
    end
    read_reg(16'h0000, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got %h expected %h", v, 16'h0000);
    end
  endtask

  task automatic test_valid_frame();
    logic [15:0] v;
    send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b0);
    model_push(8'h1C);
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL valid_status: got %h expected %h", v, exp_status());
    end
    checks++;
    if (io_irq !== 1'b1) begin
      errors++; $display("FAIL valid_irq: got %b expected 1", io_irq);
    end
    // Two reads in a row: reading DATA must not consume the byte.
    for (int k = 0; k < 2; k++) begin
      read_reg(16'h0000, v);
      checks++;
      if (v !== {8'h00, q_exp[0]}) begin
        errors++; $display("FAIL valid_data%0d: got %h expected %h", k, v, {8'h00, q_exp[0]});
      end
    end
    write_reg(16'h0000, 16'hFFFF);
    void'(q_exp.pop_front());
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL valid_pop_status: got %h expected %h", v, exp_status());
    end
    ack_irq();
    checks++;
    if (io_irq !== 1'b0) begin
      errors++; $display("FAIL valid_ack_irq: got %b expected 0", io_irq);
    end
  endtask

  task automatic test_parity_error();
    logic [15:0] v;
    send_frame(8'h1C, 1'b1, 11, 1'b0, 1'b0);
    ferr_exp = 1'b1;
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL parity_status: got %h expected %h", v, exp_status());
    end
    checks++;
    if (io_irq !== 1'b0) begin
      errors++; $display("FAIL parity_irq: got %b expected 0", io_irq);
    end
    write_reg(16'h0001, 16'h0004);
    ferr_exp = 1'b0;
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL parity_clear: got %h expected %h", v, exp_status());
    end
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    logic [15:0] e;
    for (int b = 0; b < 17; b++) begin
      send_frame(8'(b), 1'b0, 11, 1'b0, 1'b0);
      model_push(8'(b));
    end
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL ovf_status: got %h expected %h", v, exp_status());
    end
    for (int k = 0; k < DEPTH; k++) begin
      read_reg(16'h0000, v);
      e = {8'h00, q_exp.pop_front()};
      checks++;
      if (v !== e) begin
        errors++; $display("FAIL ovf_drain%0d: got %h expected %h", k, v, e);
      end
      write_reg(16'h0000, 16'h0000);
    end
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL ovf_empty_status: got %h expected %h", v, exp_status());
    end
    read_reg(16'h0000, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++; $display("FAIL ovf_empty_data: got %h expected %h", v, 16'h0000);
    end
    // Pop when empty must be ignored.
    write_reg(16'h0000, 16'h0000);
    write_reg(16'h0001, 16'h0002);
    ovf_exp = 1'b0;
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL ovf_clear: got %h expected %h", v, exp_status());
    end
    ack_irq();
  endtask

  task automatic test_timeout();
    logic [15:0] v;
    send_frame(8'hA5, 1'b0, 5, 1'b0, 1'b0);
    repeat (2 * TIMEOUT) @(negedge clk);
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL timeout_abort_status: got %h expected %h", v, exp_status());
    end
    send_frame(8'hF0, 1'b0, 11, 1'b0, 1'b0);
    model_push(8'hF0);
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL timeout_status: got %h expected %h", v, exp_status());
    end
    read_reg(16'h0000, v);
    checks++;
    if (v !== {8'h00, q_exp[0]}) begin
      errors++; $display("FAIL timeout_data: got %h expected %h", v, {8'h00, q_exp[0]});
    end
    write_reg(16'h0000, 16'h0000);
    void'(q_exp.pop_front());
    ack_irq();
  endtask

  task automatic test_glitch();
    logic [15:0] v;
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL glitch_status: got %h expected %h", v, exp_status());
    end
    // A glitch taken as a start bit would misalign this frame.
    send_frame(8'h33, 1'b0, 11, 1'b0, 1'b0);
    model_push(8'h33);
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL glitch_frame_status: got %h expected %h", v, exp_status());
    end
    read_reg(16'h0000, v);
    checks++;
    if (v !== {8'h00, q_exp[0]}) begin
      errors++; $display("FAIL glitch_frame_data: got %h expected %h", v, {8'h00, q_exp[0]});
    end
    write_reg(16'h0000, 16'h0000);
    void'(q_exp.pop_front());
    ack_irq();
  endtask

  task automatic test_reset_midframe();
    logic [15:0] v;
    send_frame(8'h77, 1'b0, 11, 1'b0, 1'b0);
    model_push(8'h77);
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL midrst_pending: got %h expected %h", v, exp_status());
    end
    send_frame(8'h5A, 1'b0, 5, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (io_rdata !== 16'h0000) begin
      errors++; $display("FAIL midrst_rdata: got %h expected %h", io_rdata, 16'h0000);
    end
    checks++;
    if (io_irq !== 1'b0) begin
      errors++; $display("FAIL midrst_irq: got %b expected 0", io_irq);
    end
    @(negedge clk);
    reset = 1'b0;
    q_exp.delete();
    ovf_exp  = 1'b0;
    ferr_exp = 1'b0;
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL midrst_status: got %h expected %h", v, exp_status());
    end
    send_frame(8'h5A, 1'b0, 11, 1'b0, 1'b0);
    model_push(8'h5A);
    read_reg(16'h0000, v);
    checks++;
    if (v !== {8'h00, q_exp[0]}) begin
      errors++; $display("FAIL midrst_5a_data: got %h expected %h", v, {8'h00, q_exp[0]});
    end
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL midrst_5a_status: got %h expected %h", v, exp_status());
    end
    write_reg(16'h0000, 16'h0000);
    void'(q_exp.pop_front());
    ack_irq();
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic [15:0] e;
    for (int b = 0; b < DEPTH; b++) begin
      send_frame(8'h20 + 8'(b), 1'b0, 11, 1'b0, 1'b0);
      model_push(8'h20 + 8'(b));
    end
    // Full FIFO: push and pop in the same cycle.
    send_frame(8'h30, 1'b0, 11, 1'b1, 1'b0);
    void'(q_exp.pop_front());
    q_exp.push_back(8'h30);
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL full_pushpop_status: got %h expected %h", v, exp_status());
    end
    for (int k = 0; k < DEPTH; k++) begin
      read_reg(16'h0000, v);
      e = {8'h00, q_exp.pop_front()};
      checks++;
      if (v !== e) begin
        errors++; $display("FAIL full_drain%0d: got %h expected %h", k, v, e);
      end
      write_reg(16'h0000, 16'h0000);
    end
    read_reg(16'h0001, v);
    checks++;
    if (v !== exp_status()) begin
      errors++; $display("FAIL full_empty_status: got %h expected %h", v, exp_status());
    end
  endtask

  task automatic test_irq_coincident();
    logic [15:0] v;
    logic [15:0] e;
    ack_irq();
    checks++;
    if (io_irq !== 1'b0) begin
      errors++; $display("FAIL irq_pre_ack: got %b expected 0", io_irq);
    end
    send_frame(8'h41, 1'b0, 11, 1'b0, 1'b0);
    model_push(8'h41);
    checks++;
    if (io_irq !== 1'b1) begin
      errors++; $display("FAIL irq_raise: got %b expected 1", io_irq);
    end
    send_frame(8'h42, 1'b0, 11, 1'b0, 1'b1);
    model_push(8'h42);
    checks++;
    if (io_irq !== 1'b1) begin
      errors++; $display("FAIL irq_coincident: got %b expected 1", io_irq);
    end
    @(negedge clk);
    io_reset_irq = 1'b0;
    ack_irq();
    checks++;
    if (io_irq !== 1'b0) begin
      errors++; $display("FAIL irq_final_ack: got %b expected 0", io_irq);
    end
    for (int k = 0; k < 2; k++) begin
      read_reg(16'h0000, v);
      e = {8'h00, q_exp.pop_front()};
      checks++;
      if (v !== e) begin
        errors++; $display("FAIL irq_drain%0d: got %h expected %h", k, v, e);
      end
      write_reg(16'h0000, 16'h0000);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    ovf_exp      = 1'b0;
    ferr_exp     = 1'b0;
    reset        = 1'b1;
    ps2_clk      = 1'b1;
    ps2_dat      = 1'b1;
    io_raddr     = 16'h0000;
    io_waddr     = 16'h0000;
    io_wdata     = 16'h0000;
    io_wenable   = 1'b0;
    io_reset_irq = 1'b0;

    test_reset();
    test_valid_frame();
    test_parity_error();
    test_overflow();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    test_irq_coincident();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
